// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and the counter-width helper.
package serial_subtractor_pkg;

    // Default operand width shared with the other serial arithmetic blocks.
    localparam int DEFAULT_WIDTH = 8;

    // 2-bit FSM encoding; kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Full-subtractor cell built from two half-subtractor stages.
module full_subtractor_cell (
    input  logic a0,
    input  logic b0,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic br1;
    logic br2;

    // First half subtractor: a0 - b0.
    assign d1  = a0 ^ b0;
    assign br1 = ~a0 & b0;

    // Second half subtractor: (a0 - b0) - bin.
    assign d   = d1 ^ bin;
    assign br2 = ~d1 & bin;

    // A borrow from either stage propagates out.
    assign bout = br1 | br2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with a start/busy/done handshake. All outputs come straight from flops.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH:0]   res_cat;
    logic             bin_q;
    logic             d;
    logic             bout;
    logic             last;

    full_subtractor_cell u_cell (
        .a0   (a_sr[0]),
        .b0   (b_sr[0]),
        .bin  (bin_q),
        .d    (d),
        .bout (bout)
    );

    // New bit enters at the MSB; bits move toward the LSB each SHIFT edge.
    assign res_cat = {d, res_sr};
    assign last    = (cnt == CW'(WIDTH - 1));

    // Next-state decode for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last)  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register plus busy/done flops, decoded from the next state so the
    // handshake outputs are registered rather than combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);
        end
    end

    // Operand/result shift registers, borrow flop, bit counter and the
    // published result, which only changes on the final SHIFT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift registers are reset too, so an aborted operation leaves no residue.
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bin_q <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_cat[WIDTH:1];
                    bin_q  <= bout;
                    if (last) begin
                        diff   <= res_cat[WIDTH:1];
                        borrow <= bout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
